// File: rtl/trig_sync_decoder.sv
// Trigger-stream sync decoder: locks onto alternating FFFF/0000 orbit markers,
// then recovers trigger hits with a running BCID and reports marker errors.
module trig_sync_decoder #(
  parameter int BC_PERIOD = 3564,
  parameter int CONFIRM_N = 4,
  parameter int LOSS_N    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] encTrigHits,
  input  logic [11:0] emptySlotBCID,
  output logic [15:0] trigHits,
  output logic        trigValid,
  output logic [11:0] BCID,
  output logic        locked,
  output logic        markerErr,
  output logic [7:0]  errCount
);

  localparam int CW = $clog2(CONFIRM_N + 1);
  localparam int LW = $clog2(LOSS_N + 1);
  localparam logic [11:0]   LAST_BC   = 12'(BC_PERIOD - 1);
  localparam logic [CW-1:0] CONFIRM_L = CW'(CONFIRM_N);
  localparam logic [LW-1:0] LOSS_L    = LW'(LOSS_N);

  typedef enum logic [1:0] {SEARCH, CONFIRM, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [11:0]   phase_q, phase_d;
  logic [CW-1:0] match_q, match_d;
  logic [LW-1:0] miss_q, miss_d;
  logic          exp_pol_q, exp_pol_d;
  logic [15:0]   hits_q, hits_d;
  logic          valid_q, valid_d;
  logic [11:0]   bcid_q, bcid_d;
  logic          err_q, err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic marker_slot, marker_ok, is_ffff;

  assign marker_slot = (phase_q == 12'd0);
  assign marker_ok   = (encTrigHits == {16{exp_pol_q}});
  assign is_ffff     = (encTrigHits == 16'hFFFF);

  always_comb begin
    state_d   = state_q;
    phase_d   = (phase_q == LAST_BC) ? 12'd0 : phase_q + 12'd1;
    match_d   = match_q;
    miss_d    = miss_q;
    exp_pol_d = exp_pol_q;
    err_d     = 1'b0;
    valid_d   = (state_q == LOCKED) && !marker_slot;
    hits_d    = valid_d ? encTrigHits : 16'h0000;
    // BCID restarts from the configured slot value at every marker slot
    bcid_d    = marker_slot ? emptySlotBCID :
                (bcid_q == LAST_BC) ? 12'd0 : bcid_q + 12'd1;

    case (state_q)
      SEARCH: begin
        // 0000 looks like idle traffic, so only FFFF can seed a candidate phase
        if (is_ffff) begin
          state_d   = CONFIRM;
          match_d   = CW'(1);
          exp_pol_d = 1'b0;
          phase_d   = 12'd1;
        end
      end
      CONFIRM: begin
        if (marker_slot) begin
          exp_pol_d = ~exp_pol_q;
          if (marker_ok) begin
            match_d = match_q + 1'b1;
            if (match_q + 1'b1 == CONFIRM_L) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else begin
            state_d = SEARCH;
            match_d = '0;
          end
        end
      end
      LOCKED: begin
        if (marker_slot) begin
          exp_pol_d = ~exp_pol_q;
          if (marker_ok) begin
            miss_d = '0;
          end else begin
            err_d  = 1'b1;
            miss_d = miss_q + 1'b1;
            if (miss_q + 1'b1 == LOSS_L) begin
              state_d = SEARCH;
              miss_d  = '0;
              match_d = '0;
            end
          end
        end
      end
      default: state_d = SEARCH;
    endcase

    err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= SEARCH;
      phase_q   <= '0;
      match_q   <= '0;
      miss_q    <= '0;
      exp_pol_q <= 1'b0;
      hits_q    <= '0;
      valid_q   <= 1'b0;
      bcid_q    <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      exp_pol_q <= exp_pol_d;
      hits_q    <= hits_d;
      valid_q   <= valid_d;
      bcid_q    <= bcid_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign trigHits  = hits_q;
  assign trigValid = valid_q;
  assign BCID      = bcid_q;
  assign locked    = (state_q == LOCKED);
  assign markerErr = err_q;
  assign errCount  = err_cnt_q;

endmodule
